// File: rtl/phase_avg_pkg.sv
// Shared definitions for the phase averager.
//   - state_e      : controller states (IDLE / BLANK / ACCUM)
//   - width helpers: counter, phase and sum widths derived from the
//                    module parameters
//   - phase_rec_t  : result record at the default parameterisation, for
//                    the downstream per-phase result FIFO / readout
package phase_avg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ACCUM = 2'd2
  } state_e;

  // Wide enough to hold every value 0..max_time inclusive.
  function automatic int cnt_width(input int max_time);
    return $clog2(max_time + 1);
  endfunction

  // A single phase still needs a 1-bit index port.
  function automatic int ph_width(input int n_phases);
    return (n_phases > 1) ? $clog2(n_phases) : 1;
  endfunction

  // max_time samples of data_w bits each cannot overflow this width.
  function automatic int sum_width(input int data_w, input int max_time);
    return data_w + cnt_width(max_time);
  endfunction

  localparam int DEF_MAX_TIME = 32'h10000;
  localparam int DEF_N_PHASES = 2;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_CNT_W    = cnt_width(DEF_MAX_TIME);
  localparam int DEF_PH_W     = ph_width(DEF_N_PHASES);
  localparam int DEF_SUM_W    = sum_width(DEF_DATA_W, DEF_MAX_TIME);

  typedef struct packed {
    logic [DEF_SUM_W-1:0] sum;
    logic [DEF_CNT_W-1:0] count;
    logic [DEF_PH_W-1:0]  phase;
    logic                 overflow;
  } phase_rec_t;

endpackage

// File: rtl/phase_averager_blank.sv
// blank_counter: loadable down-counter that times the settling window.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val (takes priority over dec)
//   load_val     : value to load
//   dec          : decrement by one, saturating at zero
//   tc           : terminal count, high while the count is 0 or 1
module blank_counter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The cycle that sees a count of 1 is the last blanked cycle.
  assign tc = (count_q <= W'(1));

endmodule

// File: rtl/phase_averager.sv
// phase_averager: accumulates one signed sum per switching phase.
// After each phase change a programmable number of clock cycles is
// discarded, then valid samples are summed until the next change, at
// which point one record (sum, count, phase, overflow) is emitted.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   enable          : run when high; low aborts the phase without a record
//   phase           : current phase index from the output switch
//   blankCycles     : settling cycles, captured at every phase start
//   sample          : signed ADC sample, qualified by sample_valid
//   result_*        : last record; fields hold, result_valid pulses once
module phase_averager
  import phase_avg_pkg::*;
#(
  parameter int MAX_TIME = 32'h10000,
  parameter int N_PHASES = 2,
  parameter int DATA_W   = 16,
  // Derived widths; leave at their defaults.
  parameter int CNT_W    = cnt_width(MAX_TIME),
  parameter int PH_W     = ph_width(N_PHASES),
  parameter int SUM_W    = sum_width(DATA_W, MAX_TIME)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [PH_W-1:0]   phase,
  input  logic [CNT_W-1:0]  blankCycles,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic [SUM_W-1:0]  result_sum,
  output logic [CNT_W-1:0]  result_count,
  output logic [PH_W-1:0]   result_phase,
  output logic              result_overflow,
  output logic              result_valid
);

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic [PH_W-1:0]  phase;
    logic             overflow;
  } rec_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TIME);

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  rec_t             rec_q, rec_d;
  logic             valid_q, valid_d;

  logic             blank_load;
  logic             blank_dec;
  logic             blank_tc;
  logic [SUM_W-1:0] sample_ext;

  assign sample_ext = {{(SUM_W-DATA_W){sample[DATA_W-1]}}, sample};

  blank_counter #(
    .W(CNT_W)
  ) u_blank (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (blank_load),
    .load_val (blankCycles),
    .dec      (blank_dec),
    .tc       (blank_tc)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rec_d      = rec_q;
    valid_d    = 1'b0;
    blank_load = 1'b0;
    blank_dec  = 1'b0;

    if (!enable) begin
      // Abort wins over a simultaneous phase change: nothing is emitted.
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Start of a phase; this cycle's sample is discarded.
          phase_d    = phase;
          blank_load = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          state_d    = (blankCycles == '0) ? ACCUM : BLANK;
        end
        BLANK, ACCUM: begin
          if (phase != phase_q) begin
            // Close the finished phase and restart on the new one.
            rec_d      = '{sum: acc_q, count: cnt_q, phase: phase_q, overflow: ovf_q};
            valid_d    = 1'b1;
            phase_d    = phase;
            blank_load = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            state_d    = (blankCycles == '0) ? ACCUM : BLANK;
          end else if (state_q == BLANK) begin
            blank_dec = 1'b1;
            if (blank_tc) begin
              state_d = ACCUM;
            end
          end else if (sample_valid) begin
            if (cnt_q < MAX_CNT) begin
              acc_d = acc_q + sample_ext;
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rec_q   <= rec_d;
      valid_q <= valid_d;
    end
  end

  assign result_sum      = rec_q.sum;
  assign result_count    = rec_q.count;
  assign result_phase    = rec_q.phase;
  assign result_overflow = rec_q.overflow;
  assign result_valid    = valid_q;

endmodule

// File: tb/tb_phase_averager.sv
// Self-checking bench for phase_averager. Two instances share stimulus:
// the default configuration and one with MAX_TIME=8 for saturation.
module tb_phase_averager;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        phase = 1'b0;
  logic [16:0] blank_cycles = '0;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;

  logic [32:0] r_sum;
  logic [16:0] r_cnt;
  logic        r_ph, r_ovf, r_vld;
  logic [19:0] s_sum;
  logic [3:0]  s_cnt;
  logic        s_ph, s_ovf, s_vld;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_averager dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .phase(phase),
    .blankCycles(blank_cycles), .sample(sample), .sample_valid(sample_valid),
    .result_sum(r_sum), .result_count(r_cnt), .result_phase(r_ph),
    .result_overflow(r_ovf), .result_valid(r_vld)
  );

  phase_averager #(.MAX_TIME(8)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .phase(phase),
    .blankCycles(blank_cycles[3:0]), .sample(sample), .sample_valid(sample_valid),
    .result_sum(s_sum), .result_count(s_cnt), .result_phase(s_ph),
    .result_overflow(s_ovf), .result_valid(s_vld)
  );

  // ---------------- reference model ----------------
  // Per phase: remember its start cycle and blanking length, keep every
  // valid sample arriving more than B cycles after the start; the record
  // is the first MAX_TIME of them, overflow if more arrived.
  int     cyc = 0;
  bit     m_run = 0;
  int     m_ph = 0;
  int     m_t0 = 0;
  int     m_b = 0;
  int     kept[$];
  int     maxt[2] = '{65536, 8};
  bit     e_vld[2];
  longint e_sum[2];
  int     e_cnt[2];
  int     e_ph[2];
  bit     e_ovf[2];

  function automatic void model_reset();
    m_run = 0;
    kept.delete();
    for (int d = 0; d < 2; d++) begin
      e_vld[d] = 0; e_sum[d] = 0; e_cnt[d] = 0; e_ph[d] = 0; e_ovf[d] = 0;
    end
  endfunction

  function automatic void model_update();
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) e_vld[d] = 0;
      if (!enable) begin
        m_run = 0;
        kept.delete();
      end else if (!m_run) begin
        m_run = 1; m_ph = int'(phase); m_t0 = cyc; m_b = int'(blank_cycles);
        kept.delete();
      end else if (int'(phase) != m_ph) begin
        for (int d = 0; d < 2; d++) begin
          int n;
          longint s;
          n = (kept.size() < maxt[d]) ? kept.size() : maxt[d];
          s = 0;
          for (int i = 0; i < n; i++) s += kept[i];
          e_vld[d] = 1; e_sum[d] = s; e_cnt[d] = n; e_ph[d] = m_ph;
          e_ovf[d] = (kept.size() > maxt[d]);
        end
        m_ph = int'(phase); m_t0 = cyc; m_b = int'(blank_cycles);
        kept.delete();
      end else if (sample_valid && (cyc - m_t0 > m_b)) begin
        kept.push_back(int'($signed(sample)));
      end
    end
    cyc++;
  endfunction

  // ---------------- checking helpers ----------------
  function automatic void chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endfunction

  function automatic void check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      bit v, o;
      longint s;
      int c, p;
      if (d == 0) begin
        v = r_vld; s = longint'($signed(r_sum)); c = int'(r_cnt); p = int'(r_ph); o = r_ovf;
      end else begin
        v = s_vld; s = longint'($signed(s_sum)); c = int'(s_cnt); p = int'(s_ph); o = s_ovf;
      end
      chk($sformatf("%s_d%0d_valid", tag, d), longint'(v), longint'(e_vld[d]));
      chk($sformatf("%s_d%0d_sum", tag, d), s, e_sum[d]);
      chk($sformatf("%s_d%0d_count", tag, d), longint'(c), longint'(e_cnt[d]));
      chk($sformatf("%s_d%0d_phase", tag, d), longint'(p), longint'(e_ph[d]));
      chk($sformatf("%s_d%0d_ovf", tag, d), longint'(o), longint'(e_ovf[d]));
      if (v && d == 0)
        $display("record t=%0t phase %0d count %0d sum %0d ovf %0d", $time, p, c, s, o);
    end
  endfunction

  task automatic step(input string tag, input bit en, input bit ph, input int b,
                      input int smp, input bit sv);
    @(negedge clk);
    enable = en; phase = ph; blank_cycles = 17'(b); sample = 16'(smp); sample_valid = sv;
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit     en;
    bit     ph;
    int     b;
    int     smp;
    bit     sv;
    bit     x_vld;
    int     x_ph;
    int     x_cnt;
    longint x_sum;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Zero blanking, phase toggling every cycle, then a 3-cycle dwell.
    tbl[0] = '{1, 0, 0, 7, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 7, 1, 1, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 7, 1, 1, 1, 0, 0};
    tbl[3] = '{1, 1, 0, 7, 1, 1, 0, 0, 0};
    tbl[4] = '{1, 1, 0, 7, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 1, 0, 7, 1, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 7, 1, 1, 1, 2, 14};
    tbl[7] = '{1, 0, 0, 7, 1, 0, 0, 0, 0};

    model_reset();

    // Reset held, then released with enable low and samples streaming.
    for (int i = 0; i < 3; i++) step("rst", 0, 0, 3, 123, 1);
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step("idle", 0, i[0], 2, 1000 + i, 1);
    chk("idle_valid", longint'(r_vld), 0);
    chk("idle_sum", longint'(r_sum), 0);

    // Basic: B=3, constant 5, change after 20 cycles.
    for (int i = 0; i < 20; i++) step("basic", 1, 0, 3, 5, 1);
    step("basic_chg", 1, 1, 3, 5, 1);
    chk("basic_valid", longint'(r_vld), 1);
    chk("basic_phase", longint'(r_ph), 0);
    chk("basic_count", longint'(r_cnt), 16);
    chk("basic_sum", longint'($signed(r_sum)), 80);
    chk("basic_ovf", longint'(r_ovf), 0);
    step("basic_after", 1, 1, 3, 5, 1);
    chk("basic_pulse", longint'(r_vld), 0);
    chk("basic_hold", longint'(r_cnt), 16);
    step("off", 0, 1, 0, 0, 0);

    // Negative data: B=2, 10-cycle window, valid every other cycle.
    step("neg", 1, 0, 2, 0, 1);
    step("neg", 1, 0, 2, 0, 1);
    step("neg", 1, 0, 2, 0, 1);
    for (int i = 0; i < 10; i++)
      step("neg", 1, 0, 2, (((i / 2) % 2) == 0) ? -100 : 40, (i % 2) == 0);
    step("neg_chg", 1, 1, 2, 0, 1);
    chk("neg_count", longint'(r_cnt), 5);
    chk("neg_sum", longint'($signed(r_sum)), -220);
    chk("neg_sign_msb", longint'(r_sum[32]), 1);
    step("off", 0, 1, 0, 0, 0);

    // Table: zero blanking and rapid switching.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].ph, tbl[i].b, tbl[i].smp, tbl[i].sv);
      chk($sformatf("tbl%0d_valid", i), longint'(r_vld), longint'(tbl[i].x_vld));
      if (tbl[i].x_vld) begin
        chk($sformatf("tbl%0d_phase", i), longint'(r_ph), longint'(tbl[i].x_ph));
        chk($sformatf("tbl%0d_count", i), longint'(r_cnt), longint'(tbl[i].x_cnt));
        chk($sformatf("tbl%0d_sum", i), longint'($signed(r_sum)), tbl[i].x_sum);
      end
    end
    step("off", 0, 0, 0, 0, 0);

    // Saturation: 20 valid samples of 1; small instance caps at 8.
    step("sat", 1, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) step("sat", 1, 0, 0, 1, 1);
    step("sat_chg", 1, 1, 0, 1, 1);
    chk("sat_s_count", longint'(s_cnt), 8);
    chk("sat_s_sum", longint'($signed(s_sum)), 8);
    chk("sat_s_ovf", longint'(s_ovf), 1);
    chk("sat_count", longint'(r_cnt), 20);
    chk("sat_ovf", longint'(r_ovf), 0);
    step("off", 0, 1, 0, 0, 0);

    // Abort mid-ACCUM coinciding with a phase change, then restart.
    step("abort", 1, 0, 1, 3, 1);
    step("abort", 1, 0, 1, 3, 1);
    for (int i = 0; i < 4; i++) step("abort", 1, 0, 1, 3, 1);
    step("abort_fall", 0, 1, 1, 3, 1);
    chk("abort_no_rec", longint'(r_vld), 0);
    step("abort_re", 1, 1, 1, 3, 1);
    chk("abort_re_no_rec", longint'(r_vld), 0);
    step("abort_re", 1, 1, 1, 3, 1);
    for (int i = 0; i < 3; i++) step("abort_re", 1, 1, 1, 3, 1);
    step("abort_chg", 1, 0, 1, 3, 1);
    chk("abort_rec_valid", longint'(r_vld), 1);
    chk("abort_rec_phase", longint'(r_ph), 1);
    chk("abort_rec_count", longint'(r_cnt), 3);
    chk("abort_rec_sum", longint'($signed(r_sum)), 9);

    // Reset asserted while that record's valid is high.
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    chk("rst_async_valid", longint'(r_vld), 0);
    chk("rst_async_count", longint'(r_cnt), 0);
    for (int i = 0; i < 2; i++) step("rst_hold", 1, i[0], 1, 3, 1);
    @(negedge clk); reset_n = 1'b1;
    step("off", 0, 0, 0, 0, 0);

    // Randomised traffic against the model.
    begin
      bit cur_ph;
      cur_ph = 0;
      for (int i = 0; i < 3000; i++) begin
        bit en;
        en = ($urandom_range(0, 99) != 0);
        if ($urandom_range(0, 7) == 0) cur_ph = ~cur_ph;
        step("rand", en, cur_ph, $urandom_range(0, 4), int'($urandom),
             $urandom_range(0, 2) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
